// File: rtl/mlp_feature_loader.sv
// mlp_feature_loader: streaming front-end that packs features for the MLP and returns its prediction.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   s_valid/s_ready    feature input handshake, s_data = one feature
//   mlp_inp            flattened feature vector to top.inp (slot i at [(i+1)*WIDTH_A-1 : i*WIDTH_A])
//   mlp_out            class result from top.out
//   m_valid/m_ready    prediction output handshake, m_class = captured prediction
//   vec_cnt            completed prediction handshakes (only when MLP_LOADER_COUNT_EN is defined)
module mlp_feature_loader #(
   parameter int WIDTH_A       = 8,
   parameter int NUM_A         = 4,
   parameter int OUTWIDTH      = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [WIDTH_A-1:0]       s_data,
   output logic [NUM_A*WIDTH_A-1:0] mlp_inp,
   input  logic [OUTWIDTH-1:0]      mlp_out,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [OUTWIDTH-1:0]      m_class
`ifdef MLP_LOADER_COUNT_EN
   ,
   output logic [15:0]              vec_cnt
`endif
);
   localparam int IW = $clog2(NUM_A);
   localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
   typedef enum logic [1:0] {LOAD, SETTLE, OUT} state_t;
   state_t                   r_state, w_next;
   logic [IW-1:0]            r_idx;
   logic [CW-1:0]            r_cnt;
   logic [NUM_A*WIDTH_A-1:0] r_inp;
   logic [OUTWIDTH-1:0]      r_class;
   logic                     r_s_ready, r_m_valid;
   logic                     w_accept, w_last, w_capture;
   assign w_accept  = s_valid && r_s_ready;
   assign w_last    = r_idx == IW'(NUM_A - 1);
   assign w_capture = r_state == SETTLE && r_cnt == '0;
   always_comb begin
      w_next = r_state;
      case (r_state)
         LOAD:    if (w_accept && w_last) w_next = SETTLE;
         SETTLE:  if (r_cnt == '0) w_next = OUT;
         OUT:     if (m_ready) w_next = LOAD;
         default: w_next = LOAD;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= LOAD;
         r_s_ready <= 1'b1;
         r_m_valid <= 1'b0;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_inp     <= '0;
         r_class   <= '0;
      end else begin
         r_state   <= w_next;
         // handshake flags follow the registered next state, so no input reaches them combinationally
         r_s_ready <= w_next == LOAD;
         r_m_valid <= w_next == OUT;
         if (w_accept) begin
            r_inp[r_idx*WIDTH_A +: WIDTH_A] <= s_data;
            r_idx <= w_last ? '0 : r_idx + 1'b1;
         end
         if (w_accept && w_last) r_cnt <= CW'(SETTLE_CYCLES - 1);
         else if (r_state == SETTLE && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
         if (w_capture) r_class <= mlp_out;
      end
   end
`ifdef MLP_LOADER_COUNT_EN
   logic [15:0] r_vec_cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_vec_cnt <= '0;
      else if (r_m_valid && m_ready) r_vec_cnt <= r_vec_cnt + 1'b1;
   end
   assign vec_cnt = r_vec_cnt;
`endif
   assign s_ready = r_s_ready;
   assign m_valid = r_m_valid;
   assign m_class = r_class;
   assign mlp_inp = r_inp;
endmodule

// File: tb/tb_mlp_feature_loader.sv
// tb_mlp_feature_loader: directed vector table plus corner-case sequences for mlp_feature_loader.
module tb_mlp_feature_loader;
   logic        clk = 0, rst_n = 0, s_valid = 0, m_ready = 0;
   logic [7:0]  s_data = 0;
   logic [31:0] mlp_inp;
   logic [3:0]  mlp_out, m_class;
   logic [7:0]  w_sum;
   logic        s_ready, m_valid;
   int          total = 0, bad = 0;
`ifdef MLP_LOADER_COUNT_EN
   logic [15:0] vec_cnt;
`endif
   mlp_feature_loader #(.WIDTH_A(8), .NUM_A(4), .OUTWIDTH(4), .SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .mlp_inp(mlp_inp), .mlp_out(mlp_out), .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class)
`ifdef MLP_LOADER_COUNT_EN
      , .vec_cnt(vec_cnt)
`endif
   );
   // stub MLP: class = (slot0 + slot3) mod 16
   assign w_sum   = mlp_inp[7:0] + mlp_inp[31:24];
   assign mlp_out = w_sum[3:0];
   always #5 clk = ~clk;
   typedef struct {
      logic [7:0]  f[4];
      logic [31:0] inp;
      logic [3:0]  cls;
   } vec_t;
   vec_t tbl[5];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [7:0] d);
      int n = 0;
      logic ok;
      s_valid = 1;
      s_data  = d;
      do begin
         ok = s_ready;
         tick();
         n++;
      end while (!ok && n < 20);
      s_valid = 0;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask
   task automatic wait_mv(output int n);
      n = 0;
      while (!m_valid && n < 20) begin
         tick();
         n++;
      end
      if (!m_valid) chk("mvalid_timeout", 0, 1);
   endtask
   initial begin
      int n;
      tbl[0].f = '{8'd3, 8'd7, 8'd1, 8'd9};         tbl[0].inp = 32'h09010703; tbl[0].cls = 4'hC;
      tbl[1].f = '{8'd10, 8'd20, 8'd30, 8'd40};     tbl[1].inp = 32'h281E140A; tbl[1].cls = 4'h2;
      tbl[2].f = '{8'd1, 8'd2, 8'd3, 8'd4};         tbl[2].inp = 32'h04030201; tbl[2].cls = 4'h5;
      tbl[3].f = '{8'hFF, 8'h00, 8'h00, 8'h01};     tbl[3].inp = 32'h010000FF; tbl[3].cls = 4'h0;
      tbl[4].f = '{8'h12, 8'h34, 8'h56, 8'h78};     tbl[4].inp = 32'h78563412; tbl[4].cls = 4'hA;
      // reset held, then released asynchronously mid-cycle
      repeat (2) tick();
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_class", m_class, 0);
      chk("rst_mlp_inp", mlp_inp, 0);
      #2 rst_n = 1;
      #1;
      chk("rel_s_ready", s_ready, 1);
      chk("rel_m_valid", m_valid, 0);
      tick();
      chk("rel2_m_valid", m_valid, 0);
      chk("rel2_mlp_inp", mlp_inp, 0);
`ifdef MLP_LOADER_COUNT_EN
      chk("rst_vec_cnt", vec_cnt, 0);
`endif
      // back-to-back vectors with the consumer always ready
      m_ready = 1;
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 4; j++) send(tbl[i].f[j]);
         chk($sformatf("v%0d_inp", i), mlp_inp, tbl[i].inp);
         wait_mv(n);
         chk($sformatf("v%0d_latency", i), n, 2);
         chk($sformatf("v%0d_class", i), m_class, tbl[i].cls);
         tick();
         chk($sformatf("v%0d_mv_drop", i), m_valid, 0);
         chk($sformatf("v%0d_s_ready", i), s_ready, 1);
      end
`ifdef MLP_LOADER_COUNT_EN
      chk("vec_cnt_5", vec_cnt, 5);
`endif
      // first feature of the next vector replaces only slot 0
      send(8'h55);
      chk("partial_inp", mlp_inp, 32'h78563455);
      for (int j = 1; j < 4; j++) send(8'h00);
      wait_mv(n);
      tick();
      // backpressure: prediction held, source pulses ignored
      m_ready = 0;
      send(8'd3); send(8'd7); send(8'd1); send(8'd9);
      wait_mv(n);
      chk("bp_latency", n, 2);
      for (int k = 0; k < 5; k++) begin
         s_valid = k[0];
         s_data  = 8'hEE;
         tick();
         chk($sformatf("bp_mv_%0d", k), m_valid, 1);
         chk($sformatf("bp_class_%0d", k), m_class, 4'hC);
         chk($sformatf("bp_s_ready_%0d", k), s_ready, 0);
      end
      chk("bp_inp_kept", mlp_inp, 32'h09010703);
      s_valid = 0;
      m_ready = 1;
      tick();
      chk("bp_mv_drop", m_valid, 0);
      chk("bp_s_ready", s_ready, 1);
      // gapped source: one valid cycle then two idle cycles per feature
      for (int j = 0; j < 4; j++) begin
         send(8'(10 * (j + 1)));
         if (j < 3) chk($sformatf("gap_slot%0d", j), mlp_inp[j*8 +: 8], 8'(10 * (j + 1)));
         if (j < 3) repeat (2) tick();
      end
      chk("gap_inp", mlp_inp, 32'h281E140A);
      wait_mv(n);
      chk("gap_class", m_class, 4'h2);
      tick();
      // reset mid-load discards the partial vector
      send(8'd5); send(8'd6);
      #2 rst_n = 0;
      #1;
      chk("mid_rst_inp", mlp_inp, 0);
      chk("mid_rst_s_ready", s_ready, 1);
      chk("mid_rst_class", m_class, 0);
      tick();
      rst_n = 1;
      tick();
      send(8'd1); send(8'd2); send(8'd3); send(8'd4);
      chk("after_rst_inp", mlp_inp, 32'h04030201);
      wait_mv(n);
      chk("after_rst_latency", n, 2);
      chk("after_rst_class", m_class, 4'h5);
      tick();
`ifdef MLP_LOADER_COUNT_EN
      chk("vec_cnt_after_rst", vec_cnt, 1);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
